div_unit: RTL and testbench

- Parametrised iterative radix-2 restoring divider; executes MIPS DIV/DIVU for the EX stage.
- Lives alongside ex and writes {remainder, quotient} to HI/LO.
- Generalises the existing fixed 2-cycle multi-cycle scheme (hilo_temp/cnt) to a WIDTH-bit, WIDTH+2-cycle operation.
- Adds signed/unsigned mode, divide-by-zero handling, an annul (flush) input and a start/ready handshake that ex uses to hold stallreq.

---
 rtl/div_unit.sv | 164 ++++++++++++++++
 tb/tb_div_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} WIDTH+2 edges after start is sampled,
// or 2 edges for a zero divisor. Holds the result until start drops.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH:0]     work_r;      // {partial remainder (W+1), dividend/quotient (W)}
  logic [WIDTH-1:0]     divisor_r;
  logic                 sign1_r;
  logic                 sign2_r;

  logic [WIDTH-1:0]     op1_abs_s;
  logic [WIDTH-1:0]     op2_abs_s;
  logic [2*WIDTH:0]     shifted_s;
  logic [WIDTH+1:0]     diff_s;
  logic [2*WIDTH:0]     work_next_s;
  logic [WIDTH-1:0]     quot_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

  // Operand magnitudes; the most-negative value keeps its bit pattern as an unsigned magnitude.
  always_comb begin
    op1_abs_s = opdata1_i;
    op2_abs_s = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      op1_abs_s = ~opdata1_i + ONE_W;
    end else begin
      op1_abs_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      op2_abs_s = ~opdata2_i + ONE_W;
    end else begin
      op2_abs_s = opdata2_i;
    end
  end

  // One restoring step: shift left, trial-subtract divisor from the upper bits.
  always_comb begin
    shifted_s   = work_r << 1;
    diff_s      = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, divisor_r};
    work_next_s = shifted_s;
    if (!diff_s[WIDTH+1]) begin
      work_next_s = {diff_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      work_next_s = {shifted_s[2*WIDTH:1], 1'b0};
    end
  end

  // Sign fix-up of the final magnitudes (sign flags are only set in signed mode).
  always_comb begin
    quot_fix_s = work_r[WIDTH-1:0];
    rem_fix_s  = work_r[2*WIDTH-1:WIDTH];
    if (sign1_r ^ sign2_r) begin
      quot_fix_s = ~work_r[WIDTH-1:0] + ONE_W;
    end else begin
      quot_fix_s = work_r[WIDTH-1:0];
    end
    if (sign1_r) begin
      rem_fix_s = ~work_r[2*WIDTH-1:WIDTH] + ONE_W;
    end else begin
      rem_fix_s = work_r[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with registered ready/result; annul beats completion in ON.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FREE;
      cnt_r     <= {CNT_W{1'b0}};
      work_r    <= {(2*WIDTH+1){1'b0}};
      divisor_r <= ZERO_W;
      sign1_r   <= 1'b0;
      sign2_r   <= 1'b0;
      ready_o   <= 1'b0;
      result_o  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= {(2*WIDTH){1'b0}};
          if (start_i && !annul_i) begin
            divisor_r <= op2_abs_s;
            work_r    <= {{(WIDTH+1){1'b0}}, op1_abs_s};
            sign1_r   <= signed_div_i & opdata1_i[WIDTH-1];
            sign2_r   <= signed_div_i & opdata2_i[WIDTH-1];
            cnt_r     <= {CNT_W{1'b0}};
            if (opdata2_i == ZERO_W) begin
              state_r <= BYZERO;
            end else begin
              state_r <= ON;
            end
          end else begin
            state_r <= FREE;
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state_r <= FREE;
            ready_o <= 1'b0;
          end else begin
            state_r  <= END;
            ready_o  <= 1'b1;
            result_o <= {(2*WIDTH){1'b0}};
          end
        end
        ON: begin
          if (annul_i) begin
            state_r <= FREE;
            cnt_r   <= {CNT_W{1'b0}};
            work_r  <= {(2*WIDTH+1){1'b0}};
            ready_o <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= END;
            ready_o  <= 1'b1;
            result_o <= {rem_fix_s, quot_fix_s};
          end else begin
            work_r <= work_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
          end
        end
        END: begin
          if (!start_i) begin
            state_r  <= FREE;
            ready_o  <= 1'b0;
            result_o <= {(2*WIDTH){1'b0}};
          end else begin
            state_r <= END;
          end
        end
        default: begin
          state_r  <= FREE;
          ready_o  <= 1'b0;
          result_o <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with an expected-result scoreboard queue.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference divider built on the language's own / and % operators.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // Full handshake: start, scramble operands after sampling, wait for ready, drop start.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int exp_lat;
    logic [63:0] expv;
    lat = 0;
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    sb_q.push_back(model(sgn, a, b));
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        signed_div_i = ~sgn; opdata1_i = $urandom; opdata2_i = $urandom;
      end
      if (ready_o) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (sb_q.size() > 0) expv = sb_q.pop_front();
    else expv = 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, "_result"}, result_o, expv);
    @(posedge clk); #1;
    check({tag, "_held"}, result_o, expv);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen_ready;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_div("udiv_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    check("udiv_model_const", model(1'b0, 32'hFFFF_FFFF, 32'h10), 64'h0000_000F_0FFF_FFFF);
    do_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div("div_zero", 1'b0, 32'h0000_1234, 32'd0);
    do_div("sdiv_zero", 1'b1, 32'hFFFF_0000, 32'd0);
    do_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("udiv_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("udiv_small_by_big", 1'b0, 32'd5, 32'd9);
    do_div("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // Annul on edge 10, then a fresh 100/7 sampled on edge 11.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    seen_ready = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (ready_o) seen_ready = 1;
    end
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    if (ready_o) seen_ready = 1;
    check("annul_no_ready", 64'(seen_ready), 64'd0);
    check("annul_result", result_o, 64'd0);
    @(negedge clk); annul_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    sb_q.push_back(model(1'b0, 32'd100, 32'd7));
    begin
      int lat;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (ready_o) begin lat = n; break; end
      end
      check("after_annul_latency", 64'(lat), 64'd34);
      check("after_annul_result", result_o, sb_q.pop_front());
      check("after_annul_const", result_o, {32'd2, 32'd14});
    end
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    check("after_annul_drop", result_o, 64'd0);

    // Asynchronous reset between edges while ON.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd99; opdata2_i = 32'd4; start_i = 1'b1;
    for (int n = 1; n <= 5; n++) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(ready_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(ready_o), 64'd0);

    do_div("b2b_first", 1'b1, 32'hFFFF_FC18, 32'd33);
    do_div("b2b_second", 1'b0, 32'hDEAD_BEEF, 32'h0001_0001);
    for (int i = 0; i < 3; i++) begin
      do_div("rand", i[0], $urandom, $urandom_range(1, 32'h00FF_FFFF));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
